// File: rtl/vpu_sram_rd_bridge_if.sv
// VPU source read port bundle: burst req/ack handshake, per-beat strobes and read return.
// The VPU drives the master side; the SRAM read bridge sits on the slave side.
interface vpu_sram_rd_bridge_if #(
   parameter int unsigned SRAM_BANK_CNT_LG2   = 2,
   parameter int unsigned SRAM_BANK_DEPTH_LG2 = 10,
   parameter int unsigned SRAM_DATA_WIDTH     = 256
);
   logic                           req_i;
   logic [SRAM_BANK_CNT_LG2-1:0]   rid_i;
   logic [SRAM_BANK_DEPTH_LG2-1:0] addr_i;
   logic                           reb_i;
   logic                           rlast_i;
   logic                           ack_o;
   logic [SRAM_DATA_WIDTH-1:0]     rdata_o;
   logic                           rvalid_o;
   logic                           busy_o;

   modport master (
      output req_i, rid_i, addr_i, reb_i, rlast_i,
      input  ack_o, rdata_o, rvalid_o, busy_o
   );

   modport slave (
      input  req_i, rid_i, addr_i, reb_i, rlast_i,
      output ack_o, rdata_o, rvalid_o, busy_o
   );
endinterface

// File: rtl/vpu_sram_rd_bridge.sv
// One VPU read port to SRAM bank accesses: req/ack burst handshake, registered chip
// selects, and a fixed-latency read return tracked by a {valid, bank} shift register.
module vpu_sram_rd_bridge #(
   parameter int unsigned SRAM_BANK_CNT       = 4,
   parameter int unsigned SRAM_BANK_CNT_LG2   = 2,
   parameter int unsigned SRAM_BANK_DEPTH_LG2 = 10,
   parameter int unsigned SRAM_DATA_WIDTH     = 256,
   parameter int unsigned SRAM_RD_LAT         = 2
) (
   input  logic                                     clk,
   input  logic                                     rst,
   vpu_sram_rd_bridge_if.slave                      vpu,
   output logic [SRAM_BANK_CNT-1:0]                 sram_cs_o,
   output logic [SRAM_BANK_DEPTH_LG2-1:0]           sram_addr_o,
   input  logic [SRAM_DATA_WIDTH*SRAM_BANK_CNT-1:0] sram_rdata_i
);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      STREAM,
      DRAIN
   } state_t;

   state_t                         state;
   state_t                         state_nxt;
   logic [SRAM_BANK_CNT_LG2-1:0]   rid_q;

   logic                           beat;
   logic [SRAM_BANK_CNT-1:0]       cs_nxt;
   logic [SRAM_BANK_CNT-1:0]       cs_q;
   logic [SRAM_BANK_DEPTH_LG2-1:0] addr_q;
   logic                           beat_q;
   logic [SRAM_BANK_CNT_LG2-1:0]   beat_bank_q;

   logic [SRAM_RD_LAT-1:0]         pipe_v;
   logic [SRAM_BANK_CNT_LG2-1:0]   pipe_bank [SRAM_RD_LAT];
   logic                           drain_done;

   logic [SRAM_DATA_WIDTH-1:0]     tail_data;
   logic                           rvalid_q;
   logic [SRAM_DATA_WIDTH-1:0]     rdata_q;

   logic                           ack;
   logic                           busy;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rid_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && vpu.req_i) begin
            rid_q <= vpu.rid_i;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ack       = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (vpu.req_i) begin
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            ack       = 1'b1;
            state_nxt = STREAM;
         end
         STREAM: begin
            if (beat && vpu.rlast_i) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_done) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign beat = (state == STREAM) && !vpu.reb_i;

   // Leave DRAIN once nothing will remain in the pipe after this edge; the tail
   // stage is excluded so IDLE coincides with the final rvalid cycle.
   always_comb begin
      drain_done = !beat_q;
      for (int unsigned i = 0; i + 1 < SRAM_RD_LAT; i++) begin
         if (pipe_v[i]) begin
            drain_done = 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------- issue stage
   always_comb begin
      cs_nxt = '0;
      for (int unsigned k = 0; k < SRAM_BANK_CNT; k++) begin
         cs_nxt[k] = beat && (rid_q == SRAM_BANK_CNT_LG2'(k));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cs_q        <= '0;
         addr_q      <= '0;
         beat_q      <= 1'b0;
         beat_bank_q <= '0;
      end else begin
         cs_q        <= cs_nxt;
         beat_q      <= beat;
         beat_bank_q <= rid_q;
         if (beat) begin
            addr_q <= vpu.addr_i;
         end
      end
   end

   // ---------------------------------------------------------------- return path
   // Beats to out-of-range banks still travel the pipe so every beat yields an rvalid.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_v <= '0;
         for (int unsigned i = 0; i < SRAM_RD_LAT; i++) begin
            pipe_bank[i] <= '0;
         end
      end else begin
         pipe_v[0]    <= beat_q;
         pipe_bank[0] <= beat_bank_q;
         for (int unsigned i = 1; i < SRAM_RD_LAT; i++) begin
            pipe_v[i]    <= pipe_v[i-1];
            pipe_bank[i] <= pipe_bank[i-1];
         end
      end
   end

   always_comb begin
      tail_data = '0;
      for (int unsigned k = 0; k < SRAM_BANK_CNT; k++) begin
         if (pipe_bank[SRAM_RD_LAT-1] == SRAM_BANK_CNT_LG2'(k)) begin
            tail_data = sram_rdata_i[k*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= pipe_v[SRAM_RD_LAT-1];
         if (pipe_v[SRAM_RD_LAT-1]) begin
            rdata_q <= tail_data;
         end
      end
   end

   // ---------------------------------------------------------------- outputs
   assign vpu.ack_o    = ack;
   assign vpu.busy_o   = busy;
   assign vpu.rvalid_o = rvalid_q;
   assign vpu.rdata_o  = rdata_q;
   assign sram_cs_o    = cs_q;
   assign sram_addr_o  = addr_q;

endmodule

// File: tb/tb_vpu_sram_rd_bridge.sv
// Directed bench for vpu_sram_rd_bridge with a 2-cycle SRAM model returning
// address-tagged data per bank; bank id width widened to 3 to reach rid 5.
module tb_vpu_sram_rd_bridge;

   localparam int unsigned W = 256;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    sram_cs_o;
   logic [9:0]    sram_addr_o;
   logic [4*W-1:0] sram_rdata_i;

   vpu_sram_rd_bridge_if #(
      .SRAM_BANK_CNT_LG2  (3),
      .SRAM_BANK_DEPTH_LG2(10),
      .SRAM_DATA_WIDTH    (W)
   ) vif ();

   vpu_sram_rd_bridge #(
      .SRAM_BANK_CNT      (4),
      .SRAM_BANK_CNT_LG2  (3),
      .SRAM_BANK_DEPTH_LG2(10),
      .SRAM_DATA_WIDTH    (W),
      .SRAM_RD_LAT        (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .vpu         (vif.slave),
      .sram_cs_o   (sram_cs_o),
      .sram_addr_o (sram_addr_o),
      .sram_rdata_i(sram_rdata_i)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] tag(input int k, input logic [9:0] a);
      logic [7:0] kb;
      kb = 8'(k + 1);
      return {8{kb, 14'd0, a}};
   endfunction

   // SRAM model: cs in cycle C returns data in cycle C+2
   logic [9:0] m_a1 [4];
   logic [9:0] m_a2 [4];
   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (sram_cs_o[k]) m_a1[k] <= sram_addr_o;
         m_a2[k] <= m_a1[k];
      end
   end
   always_comb begin
      sram_rdata_i = '0;
      for (int k = 0; k < 4; k++) sram_rdata_i[k*W +: W] = tag(k, m_a2[k]);
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int           rv_cyc [$];
   logic [W-1:0] rv_dat [$];
   int           cs_cyc [$];
   logic [3:0]   cs_val [$];
   logic [9:0]   cs_adr [$];
   logic         busy_h [int];
   logic [9:0]   adr_h  [int];

   always @(negedge clk) begin
      if (!rst) begin
         busy_h[cyc] = vif.busy_o;
         adr_h[cyc]  = sram_addr_o;
         if (vif.rvalid_o) begin
            rv_cyc.push_back(cyc);
            rv_dat.push_back(vif.rdata_o);
         end
         if (sram_cs_o != 4'b0) begin
            cs_cyc.push_back(cyc);
            cs_val.push_back(sram_cs_o);
            cs_adr.push_back(sram_addr_o);
         end
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      rv_cyc.delete(); rv_dat.delete();
      cs_cyc.delete(); cs_val.delete(); cs_adr.delete();
   endtask

   // Returns positioned in the first STREAM cycle
   task automatic start_burst(input logic [2:0] rid, output int ack_cyc);
      ack_cyc    = -1;
      vif.req_i  = 1'b1;
      vif.rid_i  = rid;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (vif.ack_o) begin
            ack_cyc = cyc;
            break;
         end
      end
      vif.req_i = 1'b0;
      check("ack_seen", ack_cyc >= 0, 1);
      tick();
   endtask

   task automatic beat(input logic [9:0] a, input logic last, output int bc);
      bc          = cyc;
      vif.reb_i   = 1'b0;
      vif.addr_i  = a;
      vif.rlast_i = last;
      tick();
      vif.reb_i   = 1'b1;
      vif.rlast_i = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (vif.busy_o && n < 40) begin
         tick();
         n++;
      end
      check("idle_reached", vif.busy_o, 0);
      repeat (6) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int a1, a2, bc;
      int b [4];

      // reset with request and strobe active
      vif.req_i = 1'b1; vif.rid_i = 3'd1; vif.addr_i = 10'h3FF;
      vif.reb_i = 1'b0; vif.rlast_i = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      check("rst_ack", vif.ack_o, 0);
      check("rst_rvalid", vif.rvalid_o, 0);
      check("rst_busy", vif.busy_o, 0);
      check("rst_cs", sram_cs_o, 0);
      check("rst_addr", sram_addr_o, 0);
      check("rst_rdata", vif.rdata_o, 0);
      clear_logs();
      rst = 1'b0;
      check("ack_cyc1", vif.ack_o, 0);
      tick();
      check("ack_cyc2", vif.ack_o, 1);
      vif.req_i = 1'b0; vif.rlast_i = 1'b1;
      tick();
      bc = cyc;
      tick();
      vif.reb_i = 1'b1; vif.rlast_i = 1'b0;
      wait_idle();
      check("t0_rv_cnt", rv_cyc.size(), 1);
      if (rv_cyc.size() == 1) begin
         check("t0_rv_cyc", rv_cyc[0], bc + 4);
         check("t0_rv_dat", rv_dat[0], tag(1, 10'h3FF));
      end

      // 4 back-to-back beats to bank 2
      clear_logs();
      start_burst(3'd2, a1);
      for (int i = 0; i < 4; i++) beat(10'(16 + i), i == 3, b[i]);
      wait_idle();
      check("t1_cs_cnt", cs_cyc.size(), 4);
      check("t1_rv_cnt", rv_cyc.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < cs_cyc.size()) begin
            check("t1_cs_val", cs_val[i], 4'b0100);
            check("t1_cs_cyc", cs_cyc[i], b[i] + 1);
            check("t1_cs_adr", cs_adr[i], 10'(16 + i));
         end
         if (i < rv_cyc.size()) begin
            check("t1_rv_cyc", rv_cyc[i], b[i] + 4);
            check("t1_rv_dat", rv_dat[i], tag(2, 10'(16 + i)));
         end
      end
      check("t1_busy_drain", busy_h[b[3] + 3], 1);
      check("t1_busy_done", busy_h[b[3] + 5], 0);

      // strobe pattern 0,1,1,0 with last on the second beat
      clear_logs();
      start_burst(3'd0, a1);
      beat(10'h020, 1'b0, b[0]);
      vif.addr_i = 10'h2AA;
      tick(); tick();
      beat(10'h023, 1'b1, b[1]);
      wait_idle();
      check("t2_cs_cnt", cs_cyc.size(), 2);
      check("t2_rv_cnt", rv_cyc.size(), 2);
      check("t2_addr_hold", adr_h[b[0] + 2], 10'h020);
      if (cs_cyc.size() == 2) check("t2_cs_gap", cs_cyc[1] - cs_cyc[0], 3);
      if (rv_cyc.size() == 2) begin
         check("t2_rv_cyc0", rv_cyc[0], b[0] + 4);
         check("t2_rv_cyc1", rv_cyc[1], b[1] + 4);
         check("t2_rv_dat0", rv_dat[0], tag(0, 10'h020));
         check("t2_rv_dat1", rv_dat[1], tag(0, 10'h023));
      end

      // reset with three beats in flight
      clear_logs();
      start_burst(3'd3, a1);
      beat(10'h050, 1'b0, b[0]);
      beat(10'h051, 1'b0, b[1]);
      vif.reb_i = 1'b0; vif.addr_i = 10'h052; rst = 1'b1;
      tick();
      rst = 1'b0; vif.reb_i = 1'b1;
      repeat (8) tick();
      check("t3_rv_none", rv_cyc.size(), 0);
      check("t3_idle", vif.busy_o, 0);
      check("t3_cs_zero", sram_cs_o, 0);
      clear_logs();
      start_burst(3'd1, a1);
      beat(10'h055, 1'b1, bc);
      wait_idle();
      check("t3_rv_cnt", rv_cyc.size(), 1);
      if (rv_cyc.size() == 1) begin
         check("t3_rv_cyc", rv_cyc[0], bc + 4);
         check("t3_rv_dat", rv_dat[0], tag(1, 10'h055));
      end

      // out-of-range bank id
      clear_logs();
      start_burst(3'd5, a1);
      beat(10'h030, 1'b0, b[0]);
      beat(10'h031, 1'b1, b[1]);
      wait_idle();
      check("t4_cs_cnt", cs_cyc.size(), 0);
      check("t4_rv_cnt", rv_cyc.size(), 2);
      if (rv_cyc.size() == 2) begin
         check("t4_rv_cyc1", rv_cyc[1], b[1] + 4);
         check("t4_rv_dat0", rv_dat[0], 0);
         check("t4_rv_dat1", rv_dat[1], 0);
      end

      // new request raised while a single-beat burst drains
      clear_logs();
      start_burst(3'd0, a1);
      beat(10'h040, 1'b1, bc);
      start_burst(3'd1, a2);
      check("t5_ack_gap", a2 - a1, 6);
      check("t5_idle_cyc", busy_h[a1 + 5], 0);
      if (rv_cyc.size() > 0) check("t5_rv0_cyc", rv_cyc[0], a1 + 5);
      beat(10'h041, 1'b1, bc);
      wait_idle();
      check("t5_rv_cnt", rv_cyc.size(), 2);
      if (rv_cyc.size() == 2) begin
         check("t5_rv_dat0", rv_dat[0], tag(0, 10'h040));
         check("t5_rv_dat1", rv_dat[1], tag(1, 10'h041));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
